// File: rtl/uart_hex_tx_pkg.sv
// Shared types and ASCII helpers for the hex line printer.
package uart_hex_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] base;
    if (nibble < 4'd10) begin
      base = 8'h30;
    end else begin
      base = upper ? 8'h37 : 8'h57;  // 'A'-10 or 'a'-10
    end
    return base + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/uart_hex_tx_hex_digit.sv
// Combinational nibble to ASCII hex digit.
module hex_digit
  import uart_hex_tx_pkg::*;
#(
  parameter bit UPPER = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = hex_ascii(nibble, UPPER);

endmodule

// File: rtl/uart_hex_tx.sv
// Prints each accepted word as NIBBLES hex digits (MSB first), optional CR LF,
// one character per FIFO write with a mandatory idle cycle between writes.
module uart_hex_tx
  import uart_hex_tx_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter bit CRLF    = 1'b1,
  parameter bit UPPER   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NIBBLES-1:0] in_data,
  input  logic                 in_strobe,
  output logic                 in_ready,
  output logic                 overrun,
  output logic [7:0]           out_data,
  output logic                 out_strobe,
  input  logic                 out_ready
);

  localparam int W     = 4 * NIBBLES;
  localparam int L     = NIBBLES + (CRLF ? 2 : 0);
  localparam int IDX_W = $clog2(NIBBLES + 3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(L - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(NIBBLES);
  localparam logic [IDX_W-1:0] LF_IDX   = IDX_W'(NIBBLES + 1);

  state_t             state_reg, state_next;
  logic [W-1:0]       shift_reg, shift_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               in_ready_reg, in_ready_next;
  logic               overrun_reg, overrun_next;
  logic [7:0]         out_data_reg, out_data_next;
  logic               out_strobe_reg, out_strobe_next;
  logic [7:0]         digit_char;
  logic [7:0]         cur_char;

  // Only the top nibble is ever converted; GAP shifts the next one into place.
  hex_digit #(.UPPER(UPPER)) u_hex_digit (
    .nibble(shift_reg[W-1 -: 4]),
    .ascii (digit_char)
  );

  always_comb begin
    cur_char = digit_char;
    if (CRLF && idx_reg == CR_IDX) begin
      cur_char = ASCII_CR;
    end else if (CRLF && idx_reg == LF_IDX) begin
      cur_char = ASCII_LF;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    idx_next        = idx_reg;
    out_data_next   = out_data_reg;
    out_strobe_next = 1'b0;
    overrun_next    = overrun_reg | (in_strobe & ~in_ready_reg);
    case (state_reg)
      ST_IDLE: begin
        if (in_strobe && in_ready_reg) begin
          shift_next = in_data;
          idx_next   = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          out_data_next   = cur_char;
          out_strobe_next = 1'b1;
          state_next      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_IDLE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          shift_next = shift_reg << 4;
          state_next = ST_SEND;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    in_ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      idx_reg        <= '0;
      in_ready_reg   <= 1'b1;
      overrun_reg    <= 1'b0;
      out_data_reg   <= 8'h00;
      out_strobe_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      idx_reg        <= idx_next;
      in_ready_reg   <= in_ready_next;
      overrun_reg    <= overrun_next;
      out_data_reg   <= out_data_next;
      out_strobe_reg <= out_strobe_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign overrun    = overrun_reg;
  assign out_data   = out_data_reg;
  assign out_strobe = out_strobe_reg;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Scoreboard bench: three printer configurations sharing one clock and reset.
module tb_uart_hex_tx;

  typedef struct {
    int         id;
    logic [7:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: NIBBLES=8 CRLF=1 lower, dut 1: NIBBLES=8 CRLF=1 upper, dut 2: NIBBLES=2 CRLF=0
  logic [31:0] a_in_data = '0, b_in_data = '0;
  logic [7:0]  c_in_data = '0;
  logic        a_in_strobe = 0, b_in_strobe = 0, c_in_strobe = 0;
  logic        a_out_ready = 1, b_out_ready = 1, c_out_ready = 1;
  logic        a_in_ready, b_in_ready, c_in_ready;
  logic        a_overrun, b_overrun, c_overrun;
  logic [7:0]  a_out_data, b_out_data, c_out_data;
  logic        a_out_strobe, b_out_strobe, c_out_strobe;

  uart_hex_tx #(.NIBBLES(8), .CRLF(1'b1), .UPPER(1'b0)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_strobe(a_in_strobe),
    .in_ready(a_in_ready), .overrun(a_overrun), .out_data(a_out_data),
    .out_strobe(a_out_strobe), .out_ready(a_out_ready));

  uart_hex_tx #(.NIBBLES(8), .CRLF(1'b1), .UPPER(1'b1)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_strobe(b_in_strobe),
    .in_ready(b_in_ready), .overrun(b_overrun), .out_data(b_out_data),
    .out_strobe(b_out_strobe), .out_ready(b_out_ready));

  uart_hex_tx #(.NIBBLES(2), .CRLF(1'b0), .UPPER(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_strobe(c_in_strobe),
    .in_ready(c_in_ready), .overrun(c_overrun), .out_data(c_out_data),
    .out_strobe(c_out_strobe), .out_ready(c_out_ready));

  logic [2:0] st, prev_st = '0, rdy;
  logic [7:0] od [3];
  assign st    = {c_out_strobe, b_out_strobe, a_out_strobe};
  assign rdy   = {c_in_ready, b_in_ready, a_in_ready};
  assign od[0] = a_out_data;
  assign od[1] = b_out_data;
  assign od[2] = c_out_data;

  exp_t exp_q[$];
  int   stb_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (st[d]) begin
        check("no_back_to_back", 64'(prev_st[d]), 64'd0);
        stb_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'(exp_q.size()), 64'd1);
        end else begin
          check("char_dut", 64'(d), 64'(exp_q[0].id));
          check("char", 64'(od[d]), 64'(exp_q[0].ch));
          $display("dut%0d char %02h at cycle %0d", d, od[d], cyc);
          exp_q.delete(0);
        end
      end
    end
    prev_st <= st;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_str(input int id, input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back('{id: id, ch: s[i]});
  endtask

  // Raises in_strobe in the current cycle (returned as c) and drops it after one cycle.
  task automatic send(input int sel, input logic [31:0] d, output int c);
    case (sel)
      0: begin a_in_data = d; a_in_strobe = 1'b1; end
      1: begin b_in_data = d; b_in_strobe = 1'b1; end
      default: begin c_in_data = d[7:0]; c_in_strobe = 1'b1; end
    endcase
    c = cyc;
    step();
    a_in_strobe = 1'b0;
    b_in_strobe = 1'b0;
    c_in_strobe = 1'b0;
  endtask

  task automatic wait_ready(input int sel, output int rc);
    rc = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rdy[sel]) begin
        rc = cyc;
        return;
      end
    end
    check("ready_timeout", 64'(rdy[sel]), 64'd1);
  endtask

  task automatic wait_stb(input int n);
    for (int i = 0; i < 200; i++) begin
      step();
      if (stb_cyc.size() >= n) return;
    end
    check("strobe_timeout", 64'(stb_cyc.size()), 64'(n));
  endtask

  initial begin
    int c, c2, rc;

    repeat (3) step();
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_out_strobe", 64'(a_out_strobe), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'h00);
    check("rst_overrun", 64'(a_overrun), 64'd0);
    reset = 1'b1;
    repeat (2) step();

    // Basic line with timing
    stb_cyc.delete();
    push_str(0, "deadbeef\r\n");
    send(0, 32'hdeadbeef, c);
    check("a_busy_after_accept", 64'(a_in_ready), 64'd0);
    wait_ready(0, rc);
    check("a_ready_return", 64'(rc), 64'(c + 21));
    for (int k = 0; k < 10 && k < stb_cyc.size(); k++)
      check("a_strobe_cycle", 64'(stb_cyc[k]), 64'(c + 2 + 2 * k));
    check("a_line_len", 64'(stb_cyc.size()), 64'd10);
    check("a_q_empty", 64'(exp_q.size()), 64'd0);

    // Upper-case digits
    step();
    stb_cyc.delete();
    push_str(1, "0123ABCD\r\n");
    send(1, 32'h0123abcd, c);
    wait_ready(1, rc);
    check("b_ready_return", 64'(rc), 64'(c + 21));
    check("b_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure after third strobe
    step();
    stb_cyc.delete();
    push_str(0, "cafef00d\r\n");
    send(0, 32'hcafef00d, c);
    wait_stb(3);
    a_out_ready = 1'b0;
    repeat (6) step();
    a_out_ready = 1'b1;
    wait_ready(0, rc);
    check("stall_ready_return", 64'(rc), 64'(c + 26));
    if (stb_cyc.size() > 3) check("stall_4th_strobe", 64'(stb_cyc[3]), 64'(c + 13));
    check("stall_line_len", 64'(stb_cyc.size()), 64'd10);
    check("stall_q_empty", 64'(exp_q.size()), 64'd0);
    check("stall_no_overrun", 64'(a_overrun), 64'd0);

    // Strobe while busy is dropped and flags overrun
    step();
    stb_cyc.delete();
    push_str(0, "12345678\r\n");
    send(0, 32'h12345678, c);
    repeat (2) step();
    send(0, 32'h9abcdef0, c2);
    wait_ready(0, rc);
    check("ovr_ready_return", 64'(rc), 64'(c + 21));
    check("ovr_flag", 64'(a_overrun), 64'd1);
    check("ovr_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (5) step();
    check("ovr_sticky", 64'(a_overrun), 64'd1);
    check("ovr_no_extra_line", 64'(stb_cyc.size()), 64'd10);

    // Reset during the 4th character abandons the line
    stb_cyc.delete();
    push_str(0, "fedc");
    send(0, 32'hfedcba98, c);
    wait_stb(4);
    reset = 1'b0;
    step();
    check("mid_rst_strobe", 64'(a_out_strobe), 64'd0);
    check("mid_rst_ready", 64'(a_in_ready), 64'd1);
    check("mid_rst_data", 64'(a_out_data), 64'h00);
    check("mid_rst_overrun", 64'(a_overrun), 64'd0);
    reset = 1'b1;
    repeat (10) step();
    check("mid_rst_no_resume", 64'(stb_cyc.size()), 64'd4);
    push_str(0, "00c0ffee\r\n");
    send(0, 32'h00c0ffee, c);
    wait_ready(0, rc);
    check("post_rst_ready_return", 64'(rc), 64'(c + 21));
    check("post_rst_q_empty", 64'(exp_q.size()), 64'd0);

    // Two-digit words back to back
    step();
    stb_cyc.delete();
    push_str(2, "00ff");
    send(2, 32'h00, c);
    wait_ready(2, rc);
    send(2, 32'hff, c2);
    check("c_second_accept", 64'(c2 - c), 64'd5);
    wait_ready(2, rc);
    check("c_ready_return", 64'(rc), 64'(c2 + 5));
    check("c_line_len", 64'(stb_cyc.size()), 64'd4);
    check("c_q_empty", 64'(exp_q.size()), 64'd0);
    check("c_no_overrun", 64'(c_overrun), 64'd0);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_hex_tx.md
# uart_hex_tx

Formats fixed-width binary words as ASCII hexadecimal lines and feeds them, one character at a time, into the UART transmit FIFO (`uart_tx_fifo`) via its `data` / `data_strobe` / `ready` handshake. It sits directly upstream of the TX FIFO and replaces ad-hoc character generators in debug and sniffer tops. Each accepted word becomes `NIBBLES` hex digits, most-significant nibble first, optionally followed by CR LF.

## Interface
- `NIBBLES`, 8: number of hex digits per word. Valid range 1..16; input width is 4*NIBBLES.
- `CRLF`, 1: when 1, append 8'h0d then 8'h0a after the digits.
- `UPPER`, 0: when 1, digits a-f are emitted as 8'h41-8'h46; when 0, as 8'h61-8'h66.

Ports:
- `clk`  in  1  system clock, 96 MHz in current tops.
- `reset`  in  1  synchronous, active-low. Low at a rising edge resets the block.
- `in_data`  in  4*NIBBLES  word to print.
- `in_strobe`  in  1  single-cycle request; `in_data` is captured when `in_strobe && in_ready`.
- `in_ready`  out  1  high while idle.
- `overrun`  out  1  sticky; set when `in_strobe` is seen while `in_ready` is 0. Cleared only by reset.
- `out_data`  out  8  ASCII character; connects to FIFO `data`.
- `out_strobe`  out  1  one-cycle write pulse; connects to FIFO `data_strobe`.
- `out_ready`  in  1  FIFO `ready`.

## Operation
- All outputs are registered.
- Reset values:
  - `in_ready`=1, `out_strobe`=0, `out_data`=8'h00, `overrun`=0.
  - State is IDLE and the character index is 0.
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_strobe`, latch `in_data` into the shift register, clear the index, and go to SEND.
  - SEND:
    - If `out_ready`=1, register `out_data`=char(index), pulse `out_strobe`, and go to GAP.
    - Otherwise hold; no strobe is issued.
  - GAP:
    - This state enforces the mandatory one-cycle gap after each strobe, because FIFO `ready` lags by one cycle. `out_strobe` is never high on two consecutive cycles.
    - If more characters remain, increment the index and go to SEND.
    - Otherwise go to IDLE.
- Character order:
  - Index 0..NIBBLES-1 gives hex digits. Nibble `in_data[4*(NIBBLES-i)-1 -: 4]` maps 0-9 to 8'h30-8'h39 and 10-15 to a-f per `UPPER`.
  - If `CRLF`=1, index NIBBLES gives 8'h0d and index NIBBLES+1 gives 8'h0a.
  - Line length L = NIBBLES + 2*CRLF.
- Index counter width is $clog2(NIBBLES+3). The comparison for the last character is against L-1. No wrap-around.
- `in_strobe` while busy is dropped: the latched word and the output stream are unaffected, and `overrun` is set.
- `in_strobe` in the same cycle that GAP returns to IDLE is not accepted, because `in_ready` is still 0. It sets `overrun`.
- If `out_ready` drops mid-line, the current character is held and re-offered when ready returns. The character is never skipped or duplicated.
- If reset is asserted mid-line, the partial line is abandoned, `out_strobe` is 0 the next cycle, and nothing resumes.

## Timing
- Word accepted at the edge ending cycle N. In cycle N+1, `in_ready`=0.
- With `out_ready` constantly 1:
  - Character k has `out_strobe` high in cycle N+2+2k.
  - For L=10, the last strobe is in cycle N+20, and `in_ready`=1 in cycle N+21.
- Maximum sustained throughput is one word per 2L+1 cycles.
- Each cycle `out_ready`=0 while in SEND adds one cycle of latency.

## Structure
- Shared include `util.v` gets:
  - constants `ASCII_CR`=8'h0d and `ASCII_LF`=8'h0a;
  - a `hex_ascii(nibble, upper)` function.
- One natural sub-module, `hex_digit`: combinational nibble-to-ASCII converter with an `UPPER` parameter. It is instantiated once, on the top nibble of the shift register.
- The shift register shifts left by 4 in GAP, so no wide mux is needed.

## Test plan
- NIBBLES=8, CRLF=1, `out_ready`=1, `in_data`=32'hdeadbeef -> FIFO receives "deadbeef\r\n"; strobes two cycles apart; `in_ready` returns 21 cycles after accept.
- UPPER=1, `in_data`=32'h0123abcd -> "0123ABCD\r\n"; digits 0-9 map to 8'h30-8'h39.
- `out_ready` held 0 for 5 cycles after the third strobe -> the fourth character is held, then emitted once; total line intact; latency +5.
- Second `in_strobe` 3 cycles after first accept -> first line unchanged, second word ignored, `overrun`=1 until reset.
- Reset asserted during the 4th character -> `out_strobe`=0 and `in_ready`=1 after the reset edge; a new word then prints as a complete line.
- NIBBLES=2, CRLF=0, words 8'h00, 8'hff back-to-back at `in_ready` -> "00ff"; second accept 5 cycles after first.
